ram_sp_arbiter: RTL and testbench
=================================

RAM_SP_ARBITER -- requirements
Module: ram_sp_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8: data word width; SHALL match the attached single-port RAM.
REQ-002 Parameter ADDR_WIDTH, default 8: address width; SHALL match the attached single-port RAM.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 a_req, b_req  in  1 each  access request from port A / port B.
REQ-006 a_we, b_we  in  1 each  1 = write, 0 = read.
REQ-007 a_addr, b_addr  in  ADDR_WIDTH each  access address.
REQ-008 a_wdata, b_wdata  in  DATA_WIDTH each  write data.
REQ-009 a_gnt, b_gnt  out  1 each  one-cycle grant pulse.
REQ-010 a_rvalid, b_rvalid  out  1 each  one-cycle read-data-valid pulse.
REQ-011 a_rdata, b_rdata  out  DATA_WIDTH each  read data, valid only when the matching rvalid is high.
REQ-012 ram_cs, ram_we, ram_oe  out  1 each  RAM chip select, write enable, output enable.
REQ-013 ram_addr  out  ADDR_WIDTH  RAM address.
REQ-014 ram_wdata  out  DATA_WIDTH, and ram_wdata_oe  out  1: write data and tri-state enable for the shared RAM data bus.
REQ-015 ram_rdata  in  DATA_WIDTH  RAM data bus as observed by this block.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have four states: IDLE, WRITE, READ, READ_CAP.
REQ-018 IDLE: if any req is high, latch the winner's we/addr/wdata, then go to WRITE (we=1) or READ (we=0); otherwise stay in IDLE.
REQ-019 Arbitration: one requester -> grant it; both -> grant the port not granted last (round-robin); the last-grant register updates on every grant.
REQ-020 The winner's gnt SHALL be high for exactly the first cycle of WRITE or READ; both gnt outputs SHALL never be high together.
REQ-021 A requester SHALL hold req/we/addr/wdata stable until it sees gnt; in the gnt cycle it may drop req or present a new request.
REQ-022 WRITE (1 cycle): ram_cs=1, ram_we=1, ram_oe=0, ram_wdata_oe=1, ram_addr/ram_wdata = latched values; next state IDLE.
REQ-023 READ (1 cycle): ram_cs=1, ram_we=0, ram_oe=1, ram_wdata_oe=0; next state READ_CAP.
REQ-024 READ_CAP (1 cycle): same RAM controls as READ; ram_rdata SHALL be captured into the granted port's rdata at the end of this cycle; next state IDLE.
REQ-025 The granted port's rvalid SHALL pulse for the one cycle after READ_CAP; rdata SHALL hold its value until the next read for that port.
REQ-026 Latency from req sampled in IDLE: write gnt +1 cycle, RAM written at the end of that cycle; read rvalid +3 cycles.
REQ-027 Throughput: 2 cycles per write and 3 cycles per read, including the IDLE arbitration cycle.
REQ-028 ram_wdata_oe SHALL never be high while ram_oe is high, so there is no bus contention.
REQ-029 In IDLE, all ram_* controls SHALL be 0; ram_addr and ram_wdata hold their last values.
REQ-030 All ram_* and gnt outputs SHALL be driven from registers or decoded only from the state register, so they are glitch-free.
REQ-031 Address width: no wrap logic; addresses pass through unmodified.

Reset
REQ-032 When reset_n is low: state=IDLE; all gnt, rvalid, ram_cs, ram_we, ram_oe, ram_wdata_oe and busy = 0; ram_addr, ram_wdata and all rdata = 0; last-grant = B, so A wins the first contention.
REQ-033 Reset mid-operation SHALL abort the access: no rvalid is issued, and a write in progress is not guaranteed to complete.
REQ-034 After reset_n rises, the first arbitration SHALL occur at the first clock edge with a req high.

Verification
REQ-035 Reset, then a_req write addr 0x10 data 0xA5 -> a_gnt in the next cycle, ram_cs=ram_we=1 with addr 0x10 and data 0xA5, busy low 2 cycles after req.
REQ-036 Then a_req read addr 0x10 -> a_rvalid 3 cycles after req with a_rdata=0xA5; b_rvalid stays 0.
REQ-037 a_req and b_req held high together, reads of 0x01/0x02 -> grants alternate A, B, A, B; no cycle with both gnt high.
REQ-038 Back-to-back: b writes 0x20=0x3C then b reads 0x20, with req held and new fields presented in the gnt cycle -> b_rdata=0x3C, 5 cycles total.
REQ-039 reset_n pulled low during READ_CAP -> all outputs 0 immediately, no rvalid; the next read returns correct data.
REQ-040 Assertion over all tests: ram_wdata_oe & ram_oe is never 1, and gnt is always one-hot or zero.

Source files
------------

// File: rtl/ram_sp_arbiter.sv
// Two-port round-robin arbiter for a shared single-port RAM.
// Each access has a one-cycle arbitration slot in IDLE, followed by a write cycle or a read/capture pair.
module ram_sp_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  a_gnt,
    output logic                  b_gnt,
    output logic                  a_rvalid,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_wdata_oe,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  busy
);

    // state    | meaning
    // IDLE     | arbitrate; RAM controls off, address/data hold
    // WRITE    | drive write strobe and data bus for one cycle
    // READ     | output enable asserted, RAM data settling
    // READ_CAP | output enable held, RAM data captured at cycle end
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WRITE    = 2'd1;
    localparam logic [1:0] READ     = 2'd2;
    localparam logic [1:0] READ_CAP = 2'd3;

    logic [1:0] state;
    logic       last_b;   // port of the most recent grant; also steers the read capture
    logic       sel_b;
    logic       win_we;

    always_comb begin
        sel_b  = b_req && (!a_req || !last_b);
        win_we = sel_b ? b_we : a_we;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            last_b    <= 1'b1;
            a_gnt     <= 1'b0;
            b_gnt     <= 1'b0;
            a_rvalid  <= 1'b0;
            b_rvalid  <= 1'b0;
            a_rdata   <= '0;
            b_rdata   <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            a_gnt    <= 1'b0;
            b_gnt    <= 1'b0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        last_b    <= sel_b;
                        a_gnt     <= !sel_b;
                        b_gnt     <= sel_b;
                        ram_addr  <= sel_b ? b_addr : a_addr;
                        ram_wdata <= sel_b ? b_wdata : a_wdata;
                        state     <= win_we ? WRITE : READ;
                    end
                end
                WRITE:    state <= IDLE;
                READ:     state <= READ_CAP;
                READ_CAP: begin
                    state <= IDLE;
                    if (last_b) begin
                        b_rdata  <= ram_rdata;
                        b_rvalid <= 1'b1;
                    end else begin
                        a_rdata  <= ram_rdata;
                        a_rvalid <= 1'b1;
                    end
                end
                default:  state <= IDLE;
            endcase
        end
    end

    // RAM strobes decode straight from the state register so they cannot glitch
    always_comb begin
        ram_cs       = (state != IDLE);
        ram_we       = (state == WRITE);
        ram_wdata_oe = (state == WRITE);
        ram_oe       = (state == READ) || (state == READ_CAP);
        busy         = (state != IDLE);
    end

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// Scoreboard bench for ram_sp_arbiter with a behavioural single-port RAM attached.
module tb_ram_sp_arbiter;

    logic       clk;
    logic       reset_n;
    logic       a_req, a_we, b_req, b_we;
    logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
    logic       a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [7:0] a_rdata, b_rdata;
    logic       ram_cs, ram_we, ram_oe, ram_wdata_oe, busy;
    logic [7:0] ram_addr, ram_wdata, ram_rdata;

    typedef struct packed {
        logic       port;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } gnt_exp_t;

    gnt_exp_t   gnt_q[$];
    logic [7:0] a_q[$];
    logic [7:0] b_q[$];
    logic [7:0] ref_mem[256];
    logic [7:0] mem[256];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    ram_sp_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .a_rdata(a_rdata), .b_rdata(b_rdata),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wdata_oe(ram_wdata_oe),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // behavioural RAM: synchronous write, asynchronous read gated by output enable
    always @(posedge clk) if (ram_cs && ram_we) mem[ram_addr] <= ram_wdata;
    assign ram_rdata = ram_oe ? mem[ram_addr] : 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // monitor: every grant and every rvalid must match the head of its queue
    always @(negedge clk) begin
        gnt_exp_t e;
        chk("bus_contention", {31'd0, ram_wdata_oe & ram_oe}, 0);
        chk("gnt_onehot", {31'd0, a_gnt & b_gnt}, 0);
        if (a_gnt || b_gnt) begin
            if (gnt_q.size() == 0) chk("unexpected_gnt", {30'd0, a_gnt, b_gnt}, 0);
            else begin
                e = gnt_q.pop_front();
                chk("gnt_port", {31'd0, b_gnt}, {31'd0, e.port});
                chk("gnt_ram_ctrl", {29'd0, ram_cs, ram_we, ram_oe}, {29'd0, 1'b1, e.we, !e.we});
                chk("gnt_ram_addr", {24'd0, ram_addr}, {24'd0, e.addr});
                if (e.we) chk("gnt_ram_wdata", {23'd0, ram_wdata_oe, ram_wdata}, {23'd0, 1'b1, e.wdata});
            end
        end
        if (a_rvalid) begin
            if (a_q.size() == 0) chk("unexpected_a_rvalid", 1, 0);
            else chk("a_rdata", {24'd0, a_rdata}, {24'd0, a_q.pop_front()});
        end
        if (b_rvalid) begin
            if (b_q.size() == 0) chk("unexpected_b_rvalid", 1, 0);
            else chk("b_rdata", {24'd0, b_rdata}, {24'd0, b_q.pop_front()});
        end
    end

    task automatic drive(input logic port, input logic req, input logic we,
                         input logic [7:0] addr, input logic [7:0] wdata);
        if (port) begin
            b_req = req; b_we = we; b_addr = addr; b_wdata = wdata;
        end else begin
            a_req = req; a_we = we; a_addr = addr; a_wdata = wdata;
        end
    endtask

    // called just after a rising edge; returns inside the grant cycle
    task automatic issue(input logic port, input logic we, input logic [7:0] addr,
                         input logic [7:0] wdata, input int exp_lat, input bit hold, input bit exp_rv);
        int lat;
        bit got;
        gnt_exp_t e;
        e.port = port; e.we = we; e.addr = addr; e.wdata = wdata;
        gnt_q.push_back(e);
        if (we) ref_mem[addr] = wdata;
        else if (exp_rv) begin
            if (port) b_q.push_back(ref_mem[addr]);
            else a_q.push_back(ref_mem[addr]);
        end
        drive(port, 1'b1, we, addr, wdata);
        lat = 0;
        got = 0;
        while (!got && lat < 12) begin
            @(posedge clk); #1;
            lat++;
            got = port ? b_gnt : a_gnt;
        end
        chk("gnt_latency", lat, exp_lat);
        if (!hold) drive(port, 1'b0, we, addr, wdata);
    endtask

    task automatic wait_rv(input logic port, input int exp_lat);
        int lat;
        bit got;
        lat = 0;
        got = 0;
        while (!got && lat < 12) begin
            @(posedge clk); #1;
            lat++;
            got = port ? b_rvalid : a_rvalid;
        end
        chk("rvalid_latency", lat, exp_lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int start;
        int ngnt;
        int cnt;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", {23'd0, a_gnt, b_gnt, a_rvalid, b_rvalid, ram_cs, ram_we, ram_oe, ram_wdata_oe, busy}, 0);
        chk("reset_addr_wdata", {16'd0, ram_addr, ram_wdata}, 0);
        chk("reset_rdata", {16'd0, a_rdata, b_rdata}, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // single write from A
        issue(1'b0, 1'b1, 8'h10, 8'hA5, 1, 0, 0);
        chk("write_busy", {31'd0, busy}, 1);
        @(posedge clk); #1;
        chk("write_done_busy", {31'd0, busy}, 0);
        chk("idle_ctrl", {28'd0, ram_cs, ram_we, ram_oe, ram_wdata_oe}, 0);
        chk("idle_addr_hold", {24'd0, ram_addr}, 32'h10);

        // read back from A
        issue(1'b0, 1'b0, 8'h10, 8'h00, 1, 0, 1);
        wait_rv(1'b0, 2);
        @(posedge clk); #1;
        chk("a_rdata_hold", {23'd0, a_rvalid, a_rdata}, {23'd0, 1'b0, 8'hA5});

        issue(1'b0, 1'b1, 8'h01, 8'h11, 1, 0, 0);
        @(posedge clk); #1;
        issue(1'b1, 1'b1, 8'h02, 8'h22, 1, 0, 0);
        @(posedge clk); #1;

        // back-to-back B write then read, new fields presented in the grant cycle
        start = cyc;
        issue(1'b1, 1'b1, 8'h20, 8'h3C, 1, 1, 0);
        issue(1'b1, 1'b0, 8'h20, 8'h00, 2, 0, 1);
        wait_rv(1'b1, 2);
        chk("b2b_total_cycles", cyc - start, 5);

        // contention: last grant was B so A goes first
        gnt_q.push_back({1'b0, 1'b0, 8'h01, 8'h00});
        gnt_q.push_back({1'b1, 1'b0, 8'h02, 8'h00});
        gnt_q.push_back({1'b0, 1'b0, 8'h01, 8'h00});
        gnt_q.push_back({1'b1, 1'b0, 8'h02, 8'h00});
        a_q.push_back(8'h11); a_q.push_back(8'h11);
        b_q.push_back(8'h22); b_q.push_back(8'h22);
        drive(1'b0, 1'b1, 1'b0, 8'h01, 8'h00);
        drive(1'b1, 1'b1, 1'b0, 8'h02, 8'h00);
        ngnt = 0;
        cnt = 0;
        while (ngnt < 4 && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
            if (a_gnt || b_gnt) begin
                ngnt++;
                if (ngnt == 3) a_req = 1'b0;
                if (ngnt == 4) b_req = 1'b0;
            end
        end
        chk("contention_grants", ngnt, 4);
        chk("contention_cycles", cnt, 10);
        wait_rv(1'b1, 2);
        @(posedge clk); #1;

        // reset during READ_CAP aborts the read
        issue(1'b0, 1'b0, 8'h10, 8'h00, 1, 0, 0);
        @(posedge clk); #1;
        chk("in_read_cap", {30'd0, ram_oe, busy}, 3);
        reset_n = 1'b0;
        #1;
        chk("abort_ctrl", {23'd0, a_gnt, b_gnt, a_rvalid, b_rvalid, ram_cs, ram_we, ram_oe, ram_wdata_oe, busy}, 0);
        chk("abort_addr_rdata", {ram_addr, ram_wdata, a_rdata, b_rdata}, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_no_rvalid", {30'd0, a_rvalid, b_rvalid}, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        issue(1'b0, 1'b0, 8'h10, 8'h00, 1, 0, 1);
        wait_rv(1'b0, 2);
        issue(1'b1, 1'b0, 8'h20, 8'h00, 1, 0, 1);
        wait_rv(1'b1, 2);

        repeat (3) @(posedge clk);
        #1;
        chk("gnt_queue_empty", gnt_q.size(), 0);
        chk("rdata_queues_empty", a_q.size() + b_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
